ysyx_22051013_lsu_ctrl: RTL
===========================

# ysyx_22051013_lsu_ctrl

Load/store unit controller that consumes the 4-bit `mem_ctl` access code produced by the instruction decoder and carries it out against the data memory port. It accepts one access at a time from the execute stage, aligns store data and byte mask, runs a valid/ready request plus response handshake with data memory, and returns sign- or zero-extended load data to write-back. It sits between EXU and the data-memory/bus bridge.

## Interface
- `AW`, 64: address width; dmem_addr is AW bits, 8-byte aligned.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: EXU presents an access.
- `req_ready` out 1: LSU can accept; high only in IDLE.
- `mem_ctl` in 4: access code: 0001 SB, 0010 SH, 0100 SW, 0101 SD, 1001 LB, 1010 LH, 1011 LW, 1100 LD, 1101 LBU, 1110 LHU, 1111 LWU, 0000 none; other codes are treated as none.
- `addr` in AW: effective byte address.
- `wdata` in 64: store data (rs2), right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `rdata` out 64: extended load result; 0 for stores/none/misaligned.
- `misalign` out 1: valid with resp_valid; access faulted.
- `dmem_req_valid` out 1, `dmem_req_ready` in 1: request handshake.
- `dmem_we` out 1, `dmem_addr` out AW, `dmem_wdata` out 64, `dmem_wmask` out 8: request payload.
- `dmem_rsp_valid` in 1, `dmem_rdata` in 64: response; also acknowledges stores.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, capture mem_ctl, addr, wdata. Code none goes to RESP. Misaligned goes to RESP with misalign=1; this path exists only when the checker is enabled. All other codes go to REQ.
- REQ: dmem_req_valid=1 with a stable payload until dmem_req_ready, then go to WAIT. dmem_rsp_valid is ignored in REQ.
- WAIT: on dmem_rsp_valid, latch the extended load data (stores latch 0), then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no backpressure on the response.
- dmem_addr = {addr[AW-1:3], 3'b000}. Lane offset off = addr[2:0], masked to access size.
- Mask: SB 8'h01<<off; SH 8'h03<<off; SW 8'h0F<<off; SD 8'hFF. dmem_wdata = wdata<<(8*off).
- Load: shift dmem_rdata right by 8*off, take 8/16/32/64 bits. LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend.
- dmem_we=1 for store codes (mem_ctl[3]=0, nonzero). dmem_wmask=0 for loads.
- dmem_rsp_valid in IDLE or RESP is ignored; stray responses are dropped.

## Timing
- Reset values: state=IDLE, req_ready=1 (IDLE), resp_valid=0, rdata=0, misalign=0, dmem_req_valid=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wmask=0.
- Memory access latency: the request is accepted at edge N. dmem_req_valid is high from cycle N+1, with the earliest handshake in N+1. The earliest rsp is in N+2, and resp_valid is asserted in N+3. Each stall cycle of ready or rsp adds one cycle.
- None/misaligned: accepted at edge N, resp_valid in cycle N+1.
- Back-to-back: a new req is accepted in the cycle after RESP (IDLE). Throughput is at most one access per 4 cycles.
- Reset asserted mid-access: immediate return to IDLE. An in-flight request is abandoned and its response is later dropped.

## Configuration
- `YSYX_22051013_MISALIGN_CHK_EN` defined: an access whose addr is not a multiple of its size (H:2, W:4, D:8) issues no dmem traffic and completes with misalign=1, rdata=0.
- Undefined: misalign is tied 0. The offset is forced aligned (off[0] cleared for H, off[1:0] for W, off=0 for D), and the access proceeds to memory.

## Structure
- Shared package: mem_ctl code constants (same encoding the decoder emits), FSM state encoding, access-size helper.
- One sub-module, `ysyx_22051013_lsu_align`: combinational mask/shift/extend logic for both the store path and the load path. The FSM and registers stay in the top.

## Test plan
- SW, addr=0x8000_0004, wdata=0x1122_3344_AABB_CCDD, ready/rsp immediate:
  - dmem_addr=0x8000_0000, wmask=8'hF0, wdata=0xAABB_CCDD_0000_0000, we=1.
  - resp_valid 3 cycles after accept, rdata=0.
- LB at addr=…3, dmem_rdata=0x0000_0000_8000_0000 → rdata=0xFFFF_FFFF_FFFF_FF80. LBU at the same addr and data → 0x80.
- LH at addr=…1 with the checker enabled → no dmem_req_valid; resp_valid next cycle with misalign=1. With the checker disabled, the access reads lane 0.
- dmem_req_ready held low 5 cycles, then rsp delayed 3 cycles → payload stable throughout, resp_valid exactly once, latency 3+5+3 cycles.
- rst pulsed while in WAIT, followed by a stray dmem_rsp_valid in IDLE → no resp_valid, and outputs return to reset values.
- mem_ctl=0000 and mem_ctl=0011 → no dmem traffic, resp_valid next cycle, rdata=0.

Source files
------------

// File: rtl/ysyx_22051013_lsu_pkg.sv
// ysyx_22051013_lsu_pkg
// Shared definitions for the load/store unit:
//   - mem_ctl access codes (same encoding the decoder emits)
//   - controller FSM state encoding
//   - access-size type and helpers (store/load/signedness/size decode)
package ysyx_22051013_lsu_pkg;

    localparam logic [3:0] MC_NONE = 4'b0000;
    localparam logic [3:0] MC_SB   = 4'b0001;
    localparam logic [3:0] MC_SH   = 4'b0010;
    localparam logic [3:0] MC_SW   = 4'b0100;
    localparam logic [3:0] MC_SD   = 4'b0101;
    localparam logic [3:0] MC_LB   = 4'b1001;
    localparam logic [3:0] MC_LH   = 4'b1010;
    localparam logic [3:0] MC_LW   = 4'b1011;
    localparam logic [3:0] MC_LD   = 4'b1100;
    localparam logic [3:0] MC_LBU  = 4'b1101;
    localparam logic [3:0] MC_LHU  = 4'b1110;
    localparam logic [3:0] MC_LWU  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } acc_size_t;

    function automatic logic is_store(input logic [3:0] c);
        return (c == MC_SB) || (c == MC_SH) || (c == MC_SW) || (c == MC_SD);
    endfunction

    function automatic logic is_load(input logic [3:0] c);
        return (c == MC_LB) || (c == MC_LH) || (c == MC_LW) || (c == MC_LD) ||
               (c == MC_LBU) || (c == MC_LHU) || (c == MC_LWU);
    endfunction

    // Unlisted codes (e.g. 0011, 1000) fall out as "none".
    function automatic logic is_access(input logic [3:0] c);
        return is_store(c) || is_load(c);
    endfunction

    function automatic logic is_signed_load(input logic [3:0] c);
        return (c == MC_LB) || (c == MC_LH) || (c == MC_LW) || (c == MC_LD);
    endfunction

    function automatic acc_size_t acc_size(input logic [3:0] c);
        acc_size_t s;
        case (c)
            MC_SH, MC_LH, MC_LHU: s = SZ_H;
            MC_SW, MC_LW, MC_LWU: s = SZ_W;
            MC_SD, MC_LD:         s = SZ_D;
            default:              s = SZ_B;
        endcase
        return s;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_mask(input acc_size_t s);
        logic [2:0] m;
        case (s)
            SZ_H:    m = 3'b001;
            SZ_W:    m = 3'b011;
            SZ_D:    m = 3'b111;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_22051013_lsu_align.sv
// ysyx_22051013_lsu_align
// Combinational lane logic for the LSU. Store path: byte mask and data
// shifted into the 8-byte memory word. Load path: extract the addressed
// lanes from the memory word and sign/zero extend.
// The lane offset is always forced to the access's natural alignment; when
// the misalign checker is on, misaligned accesses never get here anyway.
// Ports:
//   mem_ctl     in  4   access code
//   off         in  3   byte offset within the 8-byte word (addr[2:0])
//   wdata       in  64  right-aligned store data
//   dmem_rdata  in  64  raw memory word
//   wmask       out 8   store byte mask (0 for loads / none)
//   wdata_lane  out 64  store data shifted to its lanes
//   rdata_ext   out 64  extended load result (0 for non-loads)
module ysyx_22051013_lsu_align
    import ysyx_22051013_lsu_pkg::*;
(
    input  logic [3:0]  mem_ctl,
    input  logic [2:0]  off,
    input  logic [63:0] wdata,
    input  logic [63:0] dmem_rdata,
    output logic [7:0]  wmask,
    output logic [63:0] wdata_lane,
    output logic [63:0] rdata_ext
);

    acc_size_t   sz;
    logic [2:0]  off_eff;
    logic [5:0]  bit_sh;
    logic [63:0] rd_sh;
    logic        sgn;

    assign sz         = acc_size(mem_ctl);
    assign off_eff    = off & ~size_mask(sz);
    assign bit_sh     = {off_eff, 3'b000};
    assign wdata_lane = wdata << bit_sh;
    assign rd_sh      = dmem_rdata >> bit_sh;
    assign sgn        = is_signed_load(mem_ctl);

    always_comb begin
        wmask = 8'h00;
        if (is_store(mem_ctl)) begin
            case (sz)
                SZ_B:    wmask = 8'h01 << off_eff;
                SZ_H:    wmask = 8'h03 << off_eff;
                SZ_W:    wmask = 8'h0F << off_eff;
                default: wmask = 8'hFF;
            endcase
        end
    end

    always_comb begin
        rdata_ext = 64'd0;
        if (is_load(mem_ctl)) begin
            case (sz)
                SZ_B:    rdata_ext = {{56{sgn & rd_sh[7]}},  rd_sh[7:0]};
                SZ_H:    rdata_ext = {{48{sgn & rd_sh[15]}}, rd_sh[15:0]};
                SZ_W:    rdata_ext = {{32{sgn & rd_sh[31]}}, rd_sh[31:0]};
                default: rdata_ext = rd_sh;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_22051013_lsu_ctrl.sv
// ysyx_22051013_lsu_ctrl
// Load/store controller between EXU and the data-memory port. Accepts one
// access at a time, issues a valid/ready request, waits for the response
// (which also acknowledges stores) and returns a one-cycle completion pulse
// with the extended load data.
// Build option: YSYX_22051013_MISALIGN_CHK_EN -- when defined, accesses not
// aligned to their size complete immediately with misalign=1 and no memory
// traffic; otherwise misalign is 0 and the offset is forced aligned.
// Ports:
//   clk, rst (async, active high)
//   req_valid/req_ready, mem_ctl, addr, wdata      : request from EXU
//   resp_valid, rdata, misalign                    : completion to WB
//   dmem_req_valid/dmem_req_ready, dmem_we,
//   dmem_addr, dmem_wdata, dmem_wmask              : memory request
//   dmem_rsp_valid, dmem_rdata                     : memory response
//
// state   | meaning
// IDLE    | ready for a new access
// REQ     | memory request presented, waiting for dmem_req_ready
// WAIT    | request accepted, waiting for dmem_rsp_valid
// RESP    | one-cycle completion pulse to write-back
module ysyx_22051013_lsu_ctrl
    import ysyx_22051013_lsu_pkg::*;
#(
    parameter int AW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    mem_ctl,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic          resp_valid,
    output logic [63:0]   rdata,
    output logic          misalign,
    output logic          dmem_req_valid,
    input  logic          dmem_req_ready,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [63:0]   dmem_wdata,
    output logic [7:0]    dmem_wmask,
    input  logic          dmem_rsp_valid,
    input  logic [63:0]   dmem_rdata
);

    lsu_state_t    state;
    logic [3:0]    ctl_q;
    logic [AW-1:0] addr_q;
    logic [63:0]   wdata_q;
    logic [63:0]   rdata_ext;
    logic          mis_in;

`ifdef YSYX_22051013_MISALIGN_CHK_EN
    assign mis_in = is_access(mem_ctl) &&
                    ((addr[2:0] & size_mask(acc_size(mem_ctl))) != 3'b000);
`else
    assign mis_in = 1'b0;
`endif

    // Payload comes straight from the captured request, so it stays stable
    // for the whole REQ phase regardless of what EXU drives meanwhile.
    ysyx_22051013_lsu_align u_align (
        .mem_ctl    (ctl_q),
        .off        (addr_q[2:0]),
        .wdata      (wdata_q),
        .dmem_rdata (dmem_rdata),
        .wmask      (dmem_wmask),
        .wdata_lane (dmem_wdata),
        .rdata_ext  (rdata_ext)
    );

    assign dmem_addr = {addr_q[AW-1:3], 3'b000};
    assign dmem_we   = is_store(ctl_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            ctl_q          <= MC_NONE;
            addr_q         <= '0;
            wdata_q        <= '0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            rdata          <= '0;
            misalign       <= 1'b0;
            dmem_req_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        // None and misaligned accesses keep ctl_q at none so
                        // the payload shows no store mask while idle.
                        if (!is_access(mem_ctl) || mis_in) begin
                            ctl_q      <= MC_NONE;
                            addr_q     <= addr;
                            wdata_q    <= wdata;
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            rdata      <= '0;
                            misalign   <= mis_in;
                        end else begin
                            ctl_q          <= mem_ctl;
                            addr_q         <= addr;
                            wdata_q        <= wdata;
                            state          <= ST_REQ;
                            dmem_req_valid <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        state          <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dmem_rsp_valid) begin
                        rdata      <= rdata_ext;
                        misalign   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
